// File: rtl/tex_fetch_sched_if.sv
// Texel-pair fetch scheduler bus: request in, cache read port, texel-pair out, fetch counter.
// slave = scheduler side, master = address generator / cache / pixel pipeline side.
interface tex_fetch_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_fmt;
    logic        req_dual;
    logic [18:0] req_adr1;
    logic [18:0] req_adr2;
    logic [1:0]  req_sub1;
    logic [1:0]  req_sub2;
    logic        cache_rd;
    logic [18:0] cache_adr;
    logic        cache_valid;
    logic [15:0] cache_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_tex1;
    logic [15:0] out_tex2;
    logic [15:0] stat_fetches;

    modport slave (
        input  req_valid, req_fmt, req_dual, req_adr1, req_adr2, req_sub1, req_sub2,
        input  cache_valid, cache_data, out_ready,
        output req_ready, cache_rd, cache_adr, out_valid, out_tex1, out_tex2, stat_fetches
    );

    modport master (
        output req_valid, req_fmt, req_dual, req_adr1, req_adr2, req_sub1, req_sub2,
        output cache_valid, cache_data, out_ready,
        input  req_ready, cache_rd, cache_adr, out_valid, out_tex1, out_tex2, stat_fetches
    );
endinterface

// File: rtl/tex_fetch_sched.sv
// Serialises a texel pair onto the single-port cache (shared address read once); 2-3 cycles min latency.
// Backpressure: out_valid holds the pair until out_ready; a new request is taken on that same edge.
module tex_fetch_sched (
    input  logic              clk,
    input  logic              rst,
    tex_fetch_sched_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH1 = 2'd1;
    localparam logic [1:0] S_FETCH2 = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [1:0]  r_fmt;
    logic        r_dual;
    logic [18:0] r_adr1;
    logic [18:0] r_adr2;
    logic [1:0]  r_sub1;
    logic [1:0]  r_sub2;
    logic [15:0] r_word1;
    logic [15:0] r_word2;
    logic        r_cache_rd;
    logic [18:0] r_cache_adr;
    logic [15:0] r_stat;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_hit;
    logic        w_same;

    function automatic logic [15:0] f_extract(input logic [15:0] word,
                                              input logic [1:0]  fmt,
                                              input logic [1:0]  sub);
        logic [15:0] v_sh;
        v_sh      = word;
        f_extract = word;
        if (fmt == 2'd0) begin
            v_sh      = word >> {sub, 2'b00};
            f_extract = {12'h000, v_sh[3:0]};
        end else if (fmt == 2'd1) begin
            v_sh      = word >> {sub[0], 3'b000};
            f_extract = {8'h00, v_sh[7:0]};
        end
    endfunction

    assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready);
    assign w_accept    = bus.req_valid && w_req_ready;
    // cache_valid only counts while a read is outstanding
    assign w_hit       = r_cache_rd && bus.cache_valid;
    assign w_same      = (r_adr2 == r_adr1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_FETCH1;
            S_FETCH1: if (w_hit) w_next = (r_dual && !w_same) ? S_FETCH2 : S_OUT;
            S_FETCH2: if (w_hit) w_next = S_OUT;
            default:  if (bus.out_ready) w_next = w_accept ? S_FETCH1 : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fmt       <= 2'd0;
            r_dual      <= 1'b0;
            r_adr1      <= 19'd0;
            r_adr2      <= 19'd0;
            r_sub1      <= 2'd0;
            r_sub2      <= 2'd0;
            r_word1     <= 16'h0000;
            r_word2     <= 16'h0000;
            r_cache_rd  <= 1'b0;
            r_cache_adr <= 19'd0;
            r_stat      <= 16'h0000;
        end else begin
            r_state    <= w_next;
            r_cache_rd <= (w_next == S_FETCH1) || (w_next == S_FETCH2);
            if (w_hit && (r_stat != 16'hFFFF))
                r_stat <= r_stat + 16'd1;
            if (w_accept) begin
                r_fmt       <= bus.req_fmt;
                r_dual      <= bus.req_dual;
                r_adr1      <= bus.req_adr1;
                r_adr2      <= bus.req_adr2;
                r_sub1      <= bus.req_sub1;
                r_sub2      <= bus.req_sub2;
                r_cache_adr <= bus.req_adr1;
            end
            if ((r_state == S_FETCH1) && w_hit) begin
                r_word1 <= bus.cache_data;
                if (!r_dual)
                    r_word2 <= 16'h0000;
                else if (w_same)
                    r_word2 <= bus.cache_data;
                else
                    r_cache_adr <= r_adr2;
            end
            if ((r_state == S_FETCH2) && w_hit)
                r_word2 <= bus.cache_data;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.cache_rd     = r_cache_rd;
    assign bus.cache_adr    = r_cache_adr;
    assign bus.out_valid    = (r_state == S_OUT);
    assign bus.out_tex1     = f_extract(r_word1, r_fmt, r_sub1);
    assign bus.out_tex2     = r_dual ? f_extract(r_word2, r_fmt, r_sub2) : 16'h0000;
    assign bus.stat_fetches = r_stat;
endmodule

// File: tb/tb_tex_fetch_sched.sv
// Bench for tex_fetch_sched: vector table, stall/back-to-back and mid-fetch reset sequences, random pairs.
module tb_tex_fetch_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tex_fetch_sched_if bus();
    tex_fetch_sched dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int exp_stat = 0;

    typedef struct {
        logic [1:0]  fmt;
        logic        dual;
        logic [18:0] a1;
        logic [18:0] a2;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] d1;
        logic [15:0] d2;
        int          lat;
        logic [15:0] e_t1;
        logic [15:0] e_t2;
        int          e_reads;
        int          e_cyc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level texel selection in plain integer arithmetic
    function automatic logic [15:0] ref_tex(input logic [15:0] w, input logic [1:0] fmt, input logic [1:0] sub);
        int wi;
        int v;
        wi = int'(w);
        if (fmt == 2'd0)      v = (wi / (1 << (4 * int'(sub)))) % 16;
        else if (fmt == 2'd1) v = (wi / (1 << (8 * (int'(sub) % 2)))) % 256;
        else                  v = wi;
        return 16'(v);
    endfunction

    // Issue one request with out_ready high and act as the cache (data keyed by address) until out_valid
    task automatic run_txn(input string tag, input logic [1:0] fmt, input logic dual,
                           input logic [18:0] a1, input logic [18:0] a2,
                           input logic [1:0] s1, input logic [1:0] s2,
                           input logic [15:0] d1, input logic [15:0] d2, input int lat,
                           input logic [15:0] e_t1, input logic [15:0] e_t2,
                           input int e_reads, input int e_cyc);
        logic [18:0] rd[2];
        logic [18:0] cur;
        int nreads, cyc, wcnt;
        logic done, adr_bad;
        rd[0] = '0; rd[1] = '0; cur = '0;
        bus.req_fmt = fmt; bus.req_dual = dual; bus.req_adr1 = a1; bus.req_adr2 = a2;
        bus.req_sub1 = s1; bus.req_sub2 = s2; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        nreads = 0; cyc = 0; wcnt = 0; done = 1'b0; adr_bad = 1'b0;
        while (!done && cyc < 300) begin
            cyc++;
            bus.cache_valid = 1'b0;
            if (bus.out_valid) begin
                done = 1'b1;
            end else if (bus.cache_rd) begin
                if (wcnt == 0) cur = bus.cache_adr;
                else if (bus.cache_adr !== cur) adr_bad = 1'b1;
                if (wcnt < lat) begin
                    wcnt++;
                end else begin
                    bus.cache_valid = 1'b1;
                    bus.cache_data  = (bus.cache_adr == a1) ? d1 : d2;
                    if (nreads < 2) rd[nreads] = bus.cache_adr;
                    nreads++;
                    wcnt = 0;
                end
            end
            if (!done) tick();
        end
        chk({tag, ":out_valid"}, 32'(done), 32'd1);
        chk({tag, ":latency"}, 32'(cyc), 32'(e_cyc));
        chk({tag, ":tex1"}, 32'(bus.out_tex1), 32'(e_t1));
        chk({tag, ":tex2"}, 32'(bus.out_tex2), 32'(e_t2));
        chk({tag, ":reads"}, 32'(nreads), 32'(e_reads));
        chk({tag, ":adr1"}, 32'(rd[0]), 32'(a1));
        if (e_reads == 2) chk({tag, ":adr2"}, 32'(rd[1]), 32'(a2));
        chk({tag, ":adr_stable"}, 32'(adr_bad), 32'd0);
        exp_stat += e_reads;
        chk({tag, ":stat"}, 32'(bus.stat_fetches), 32'(exp_stat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  fmt, s1, s2;
        logic        dual;
        logic [18:0] a1, a2;
        logic [15:0] d1, d2, w2, e1, e2;
        int          lat, reads;

        tbl[0] = '{2'd2, 1'b1, 19'h01234, 19'h01235, 2'd0, 2'd0, 16'hAAAA, 16'h5555, 0, 16'hAAAA, 16'h5555, 2, 3};
        tbl[1] = '{2'd0, 1'b1, 19'h00040, 19'h00040, 2'd1, 2'd3, 16'hB7C2, 16'h0000, 0, 16'h000C, 16'h000B, 1, 2};
        tbl[2] = '{2'd1, 1'b0, 19'h00777, 19'h00000, 2'd1, 2'd0, 16'h9F10, 16'h0000, 5, 16'h009F, 16'h0000, 1, 7};
        tbl[3] = '{2'd1, 1'b1, 19'h10000, 19'h10001, 2'd0, 2'd1, 16'h1234, 16'hABCD, 1, 16'h0034, 16'h00AB, 2, 5};
        tbl[4] = '{2'd3, 1'b0, 19'h7FFFF, 19'h00005, 2'd2, 2'd2, 16'hFFFF, 16'h0000, 0, 16'hFFFF, 16'h0000, 1, 2};
        tbl[5] = '{2'd0, 1'b1, 19'h00000, 19'h7FFFF, 2'd0, 2'd2, 16'h4321, 16'h8765, 2, 16'h0001, 16'h0007, 2, 7};
        tbl[6] = '{2'd2, 1'b1, 19'h12345, 19'h12345, 2'd1, 2'd2, 16'hC0DE, 16'h0000, 0, 16'hC0DE, 16'hC0DE, 1, 2};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_fmt = 2'd0; bus.req_dual = 1'b0;
        bus.req_adr1 = '0; bus.req_adr2 = '0; bus.req_sub1 = 2'd0; bus.req_sub2 = 2'd0;
        bus.cache_valid = 1'b0; bus.cache_data = 16'h0000; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:cache_rd", 32'(bus.cache_rd), 32'd0);
        chk("rst:cache_adr", 32'(bus.cache_adr), 32'd0);
        chk("rst:out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst:tex1", 32'(bus.out_tex1), 32'd0);
        chk("rst:tex2", 32'(bus.out_tex2), 32'd0);
        chk("rst:stat", 32'(bus.stat_fetches), 32'd0);
        chk("rst:req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Stray cache_valid while idle must be ignored
        bus.cache_valid = 1'b1; bus.cache_data = 16'hDEAD;
        tick(); tick();
        bus.cache_valid = 1'b0;
        chk("idle_ign:stat", 32'(bus.stat_fetches), 32'd0);
        chk("idle_ign:cache_rd", 32'(bus.cache_rd), 32'd0);
        chk("idle_ign:out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_ign:req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].fmt, tbl[i].dual, tbl[i].a1, tbl[i].a2,
                    tbl[i].s1, tbl[i].s2, tbl[i].d1, tbl[i].d2, tbl[i].lat,
                    tbl[i].e_t1, tbl[i].e_t2, tbl[i].e_reads, tbl[i].e_cyc);
        tick();

        // Output stall with the next request waiting, then back-to-back accept
        bus.req_fmt = 2'd2; bus.req_dual = 1'b0; bus.req_adr1 = 19'h00ABC; bus.req_sub1 = 2'd0;
        bus.out_ready = 1'b0; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("hold:cache_rd", 32'(bus.cache_rd), 32'd1);
        bus.cache_valid = 1'b1; bus.cache_data = 16'h1357;
        tick();
        bus.cache_valid = 1'b0;
        chk("hold:out_valid0", 32'(bus.out_valid), 32'd1);
        chk("hold:tex1_0", 32'(bus.out_tex1), 32'h1357);
        bus.req_fmt = 2'd1; bus.req_adr1 = 19'h00100; bus.req_sub1 = 2'd0; bus.req_valid = 1'b1;
        bus.cache_valid = 1'b1; bus.cache_data = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d:req_ready", k), 32'(bus.req_ready), 32'd0);
            chk($sformatf("hold%0d:out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d:tex1", k), 32'(bus.out_tex1), 32'h1357);
            chk($sformatf("hold%0d:tex2", k), 32'(bus.out_tex2), 32'h0000);
            tick();
        end
        bus.cache_valid = 1'b0;
        exp_stat += 1;
        chk("hold:stat", 32'(bus.stat_fetches), 32'(exp_stat));
        bus.out_ready = 1'b1;
        #1;
        chk("hold:req_ready_rel", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b:out_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b:cache_rd", 32'(bus.cache_rd), 32'd1);
        chk("b2b:cache_adr", 32'(bus.cache_adr), 32'h00100);
        bus.cache_valid = 1'b1; bus.cache_data = 16'h2468;
        tick();
        bus.cache_valid = 1'b0;
        exp_stat += 1;
        chk("b2b:out_valid1", 32'(bus.out_valid), 32'd1);
        chk("b2b:tex1", 32'(bus.out_tex1), 32'h0068);
        chk("b2b:stat", 32'(bus.stat_fetches), 32'(exp_stat));
        tick();

        for (int n = 0; n < 40; n++) begin
            fmt  = 2'($urandom);
            dual = 1'($urandom);
            a1   = 19'($urandom);
            a2   = ($urandom_range(0, 2) == 0) ? a1 : 19'($urandom);
            s1   = 2'($urandom);
            s2   = 2'($urandom);
            d1   = 16'($urandom);
            d2   = 16'($urandom);
            lat  = int'($urandom_range(0, 3));
            reads = (dual && (a2 != a1)) ? 2 : 1;
            w2 = !dual ? 16'h0000 : ((a2 == a1) ? d1 : d2);
            e1 = ref_tex(d1, fmt, s1);
            e2 = dual ? ref_tex(w2, fmt, s2) : 16'h0000;
            run_txn($sformatf("rnd%0d", n), fmt, dual, a1, a2, s1, s2, d1, d2, lat,
                    e1, e2, reads, reads * (lat + 1) + 1);
        end
        tick();

        // Reset while the second read is outstanding, with a late cache_valid
        bus.req_fmt = 2'd2; bus.req_dual = 1'b1; bus.req_adr1 = 19'h00010; bus.req_adr2 = 19'h00020;
        bus.out_ready = 1'b1; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("rstf:cache_rd1", 32'(bus.cache_rd), 32'd1);
        bus.cache_valid = 1'b1; bus.cache_data = 16'h1111;
        tick();
        bus.cache_valid = 1'b0;
        chk("rstf:cache_rd2", 32'(bus.cache_rd), 32'd1);
        chk("rstf:cache_adr2", 32'(bus.cache_adr), 32'h00020);
        #2;
        rst = 1'b1;
        #1;
        chk("rstf:cache_rd_async", 32'(bus.cache_rd), 32'd0);
        chk("rstf:out_valid_async", 32'(bus.out_valid), 32'd0);
        chk("rstf:stat_async", 32'(bus.stat_fetches), 32'd0);
        bus.cache_valid = 1'b1; bus.cache_data = 16'h2222;
        tick();
        rst = 1'b0;
        exp_stat = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstf%0d:out_valid", k), 32'(bus.out_valid), 32'd0);
            chk($sformatf("rstf%0d:cache_rd", k), 32'(bus.cache_rd), 32'd0);
            chk($sformatf("rstf%0d:stat", k), 32'(bus.stat_fetches), 32'd0);
        end
        bus.cache_valid = 1'b0;
        chk("rstf:tex1", 32'(bus.out_tex1), 32'd0);
        chk("rstf:tex2", 32'(bus.out_tex2), 32'd0);
        chk("rstf:req_ready", 32'(bus.req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tex_fetch_sched.md
# tex_fetch_sched

Texel-pair fetch scheduler between the texture address generator and the single-port texture cache. It accepts one request carrying two halfword texel addresses with their sub-word selectors, and serialises them onto the cache read port, fetching a shared address only once. It extracts the 4/8/16-bit texel values and presents the pair to the pixel pipeline through a valid/ready handshake.

## Interface
Parameters:
- none; widths are fixed by the VRAM halfword address (19 bits) and the 16-bit VRAM word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_fmt  in  2  texture format: 0 = 4-bit, 1 = 8-bit, 2 and 3 = 16-bit.
- req_dual  in  1  1 = fetch texel 1 and texel 2; 0 = texel 1 only.
- req_adr1, req_adr2  in  19  halfword addresses of texel 1 and texel 2.
- req_sub1, req_sub2  in  2  U low bits: nibble index (4-bit) or byte index in bit 0 (8-bit); ignored for 16-bit.
- cache_rd  out  1  cache read request, held high until cache_valid.
- cache_adr  out  19  halfword address, stable while cache_rd = 1.
- cache_valid  in  1  read data valid; sampled only while cache_rd = 1.
- cache_data  in  16  read word.
- out_valid  out  1  texel pair available.
- out_ready  in  1  consumer takes the pair.
- out_tex1, out_tex2  out  16  zero-extended texel values.
- stat_fetches  out  16  count of completed cache reads, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, FETCH1, FETCH2, OUT. Reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - On accept: latch all request fields, then go to FETCH1.
- FETCH1:
  - cache_rd = 1, cache_adr = adr1.
  - On cache_valid: store word1.
  - If dual and adr2 ≠ adr1: go to FETCH2.
  - If dual and adr2 = adr1: word2 = word1, go to OUT. No second read is issued.
  - If not dual: word2 = 0, go to OUT.
- FETCH2:
  - cache_rd = 1, cache_adr = adr2.
  - On cache_valid: store word2, go to OUT.
- OUT:
  - out_valid = 1.
  - req_ready = out_ready, so a new request can be accepted back-to-back.
  - out_ready & accept: go to FETCH1 with the new request.
  - out_ready without a new request: go to IDLE.
  - out_ready = 0: hold all outputs.
- Texel extraction (combinational from stored word and latched sub/fmt):
  - 4-bit: (word >> 4·sub)[3:0], zero-extended to 16 bits.
  - 8-bit: (word >> 8·sub[0])[7:0], zero-extended to 16 bits.
  - 16-bit: word unchanged.
  - out_tex2 = 0 when dual = 0.
- stat_fetches increments by 1 on every cycle where cache_rd & cache_valid, saturating at 0xFFFF.

## Timing
- cache_rd and cache_adr are registered outputs. cache_rd rises in the cycle after acceptance.
- cache_valid may assert in any cycle with cache_rd = 1, including the first. Cache latency is unbounded; the FSM waits.
- Minimum latency from accept edge to out_valid:
  - Two distinct addresses: 3 cycles.
  - Single texel or shared address: 2 cycles.
- Peak throughput:
  - Dual distinct fetches: one pair per 3 cycles.
  - Single texel or shared address: one pair per 2 cycles.
- cache_valid while cache_rd = 0 is ignored, with no state change and no count.
- Reset values:
  - cache_rd = 0, cache_adr = 0.
  - out_valid = 0, out_tex1 = out_tex2 = 0.
  - stat_fetches = 0.
  - req_ready = 1 (IDLE).
- Reset mid-fetch: cache_rd drops immediately (asynchronous) and any pending request is discarded. A cache_valid arriving after reset is ignored.
- out_tex1 and out_tex2 are stable while out_valid & !out_ready.

## Test plan
- 16-bit dual, adr1 = 0x01234, adr2 = 0x01235, cache valid same cycle with data 0xAAAA then 0x5555 -> two reads in order; out_valid 3 cycles after accept; tex1 = 0xAAAA, tex2 = 0x5555; stat_fetches = 2.
- 4-bit dual, adr1 = adr2 = 0x00040, sub1 = 1, sub2 = 3, data 0xB7C2 -> one read only; tex1 = 0x000C, tex2 = 0x000B; out_valid 2 cycles after accept.
- 8-bit single, sub1 = 1, data 0x9F10, 5-cycle cache latency -> cache_rd held 5 cycles with cache_adr stable; tex1 = 0x009F, tex2 = 0.
- out_ready = 0 for 4 cycles then 1, with req_valid held -> outputs frozen; new request accepted on the out_ready edge; cache_rd rises the next cycle.
- rst asserted during FETCH2 with a late cache_valid injected -> cache_rd = 0 and out_valid = 0 immediately; stat_fetches = 0; no output is produced for the aborted request.
